control_operandos: RTL
======================

# control_operandos

Keypad-entry sequencer for the BCD-to-binary converter in the calculator front end. It collects up to three decimal digits per operand from key strobes and presents them as three BCD digits. It pulses the converter enable and captures the 11-bit result as operand A or B. When both operands are latched it signals ready to the arithmetic stage.

## Interface

- `TIMEOUT_CYCLES`, default 27_000_000: idle cycles before auto-clear. Used only with `CTRL_TIMEOUT_EN`.
- `clk` in 1: sole clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `key_valid` in 1: one-cycle strobe; `key_code` is valid in that cycle.
- `key_code` in 4: key codes.
  - 0x0–0x9 digit.
  - 0xA operator (close A).
  - 0xB enter (close B).
  - 0xC clear.
  - 0xD–0xF ignored.
- `conv_en` out 1: converter enable, one-cycle pulse.
- `conv_d2`, `conv_d1`, `conv_d0` out 4 each: BCD hundreds, tens and units held for the converter.
- `conv_value` in 11: converter result, registered; valid the cycle after `conv_en`.
- `op_a`, `op_b` out 11: latched operands, 0–999.
- `busy` out 1: high in CONV/WAIT states; keys are ignored while high.
- `ready` out 1: one-cycle pulse when both operands are latched.

## Operation

- States:
  - `ENT_A` (reset state)
  - `CONV_A`
  - `WAIT_A`
  - `ENT_B`
  - `CONV_B`
  - `WAIT_B`
  - `DONE`
- Digit key in `ENT_A` or `ENT_B`:
  - Shift left: d2←d1, d1←d0, d0←key.
  - A 2-bit count saturates at 3; digits after the third are ignored and the digit registers are unchanged.
- `ENT_A` + 0xA → `CONV_A`.
- `ENT_B` + 0xB → `CONV_B`.
- Zero digits entered is legal and yields operand 0.
- `ENT_A` + 0xB is ignored. `ENT_B` + 0xA is ignored.
- `CONV_x`:
  - `conv_en`=1 for exactly this cycle; the digit registers are stable.
  - Unconditional → `WAIT_x`.
- `WAIT_x`:
  - `conv_value` is captured into `op_a` or `op_b` at the end of the cycle.
  - Digit registers and count clear to 0.
  - `WAIT_A` → `ENT_B`; `WAIT_B` → `DONE`.
- `DONE`:
  - `ready`=1 on the first cycle only. `op_a`/`op_b` hold.
  - A digit key starts a new entry: → `ENT_A` with digits cleared and the key shifted in as d0, count=1.
  - 0xA/0xB are ignored.
- 0xC clear, in any non-busy state: → `ENT_A`; digits, count, `op_a` and `op_b` all go to 0.
- Keys arriving while `busy`=1 are dropped, clear included; there is no queueing.
- Arithmetic: the converter result never exceeds 999, so no saturation logic is needed. Operands are stored at the full 11 bits.

## Timing

- Reset values: state `ENT_A`; `conv_en`, `conv_d*`, `op_a`, `op_b`, `busy` and `ready` all 0.
- Key to digit visible on `conv_d0`: 1 cycle.
- Operator strobe (cycle N) to `conv_en` (N+1); `op_a` updates at the edge ending N+2; `ENT_B` is in effect from N+3.
- Enter strobe (cycle M) to `op_b` valid and `ready` high in M+3.
- `busy` is high exactly 2 cycles per operand.
- `rst` asserted mid-conversion: next edge → reset values. Any converter result in flight is discarded.

## Configuration

- `CTRL_TIMEOUT_EN` defined:
  - An idle counter increments each cycle in `ENT_A` (count≠0) or `ENT_B`.
  - It clears on any `key_valid` and on any state change.
  - On reaching `TIMEOUT_CYCLES` it performs a clear exactly as key 0xC does.
- Undefined: no counter is synthesized; entry waits indefinitely.

## Test plan

- Reset, keys 1,2,3,A, then 4,5,B → `conv_en` pulses twice, `op_a`=123, `op_b`=45, `ready` one pulse, `busy` 2 cycles each.
- Keys 9,8,7,6,A → fourth digit ignored; `conv_d2..d0`=9,8,7; `op_a`=987.
- A immediately after reset, then B → `op_a`=0, `op_b`=0, `ready` pulses.
- Key 5 strobed during `CONV_A` or `WAIT_A` → dropped; `op_b` reflects only later digits. Key C in `ENT_B` → `op_a`=0, state `ENT_A`.
- `rst` asserted in `WAIT_B` → all outputs 0 next cycle, no `ready`. Key 7 in `DONE` → `conv_d0`=7, state `ENT_A`.
- With `CTRL_TIMEOUT_EN` and `TIMEOUT_CYCLES`=16: key 3 then 16 idle cycles → digits cleared, `ENT_A`. A key at idle cycle 15 restarts the count.

Source files
------------

// File: rtl/control_operandos_if.sv
// Keypad / converter / arithmetic-stage bundle for control_operandos.
//
// Signals:
//   key_valid  : one-cycle key strobe, key_code valid with it
//   key_code   : 4-bit key code (0-9 digit, A operator, B enter, C clear)
//   conv_en    : one-cycle converter enable
//   conv_d2..0 : BCD hundreds/tens/units held for the converter
//   conv_value : 11-bit converter result, valid the cycle after conv_en
//   op_a, op_b : latched operands
//   busy       : conversion in progress, keys dropped
//   ready      : one-cycle pulse when both operands are latched
//
// Modports: slave = the sequencer, master = keypad/converter/consumer side.
interface control_operandos_if;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        conv_en;
  logic [3:0]  conv_d2;
  logic [3:0]  conv_d1;
  logic [3:0]  conv_d0;
  logic [10:0] conv_value;
  logic [10:0] op_a;
  logic [10:0] op_b;
  logic        busy;
  logic        ready;

  modport slave (
    input  key_valid, key_code, conv_value,
    output conv_en, conv_d2, conv_d1, conv_d0, op_a, op_b, busy, ready
  );

  modport master (
    output key_valid, key_code, conv_value,
    input  conv_en, conv_d2, conv_d1, conv_d0, op_a, op_b, busy, ready
  );
endinterface

// File: rtl/control_operandos.sv
// Keypad-entry sequencer for the BCD-to-binary converter.
//
// Collects up to three decimal digits per operand, pulses the converter,
// captures the 11-bit result as operand A (closed by key 0xA) or operand B
// (closed by key 0xB), then pulses ready. Key 0xC clears everything when not
// busy; keys arriving while busy are dropped.
//
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : control_operandos_if.slave (keys, converter handshake, operands)
//
// Parameter:
//   TIMEOUT_CYCLES : idle cycles before an automatic clear
//
// Build option:
//   CTRL_TIMEOUT_EN : when defined, an idle counter clears a stalled entry
//                     after TIMEOUT_CYCLES cycles; otherwise entry waits
//                     indefinitely and no counter exists.
module control_operandos #(
  parameter int unsigned TIMEOUT_CYCLES = 27_000_000
) (
  input logic                 clk,
  input logic                 rst,
  control_operandos_if.slave  bus
);

  typedef enum logic [2:0] {
    ENT_A  = 3'd0,
    CONV_A = 3'd1,
    WAIT_A = 3'd2,
    ENT_B  = 3'd3,
    CONV_B = 3'd4,
    WAIT_B = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t     state;
  logic [1:0] cnt;

  logic key_dig;
  logic key_op;
  logic key_ent;
  logic key_clr;
  logic entry;
  logic idle_hit;
  logic do_clr;

  always_comb begin
    key_dig = 1'b0;
    key_op  = 1'b0;
    key_ent = 1'b0;
    key_clr = 1'b0;
    if (bus.key_valid) begin
      key_dig = (bus.key_code <= 4'd9);
      key_op  = (bus.key_code == 4'hA);
      key_ent = (bus.key_code == 4'hB);
      key_clr = (bus.key_code == 4'hC);
    end
  end

  assign entry = (state == ENT_A) || (state == ENT_B);

  // Clear is only honoured when not busy; the timeout acts exactly like 0xC.
  assign do_clr = (entry || (state == DONE)) && (key_clr || idle_hit);

`ifdef CTRL_TIMEOUT_EN
  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic              counting;

  // An empty operand A is not worth timing out; a pending B always is.
  assign counting = ((state == ENT_A) && (cnt != 2'd0)) || (state == ENT_B);
  assign idle_hit = counting && (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1));

  // Every state change is caused by a key, a timeout, or happens outside the
  // counting states, so those three conditions cover the restart rule.
  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt <= '0;
    end else if (bus.key_valid || !counting || idle_hit) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end
`else
  assign idle_hit = 1'b0;

  // TIMEOUT_CYCLES has no effect in this build.
  if (TIMEOUT_CYCLES == 0) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ENT_A;
      cnt         <= 2'd0;
      bus.conv_d2 <= 4'd0;
      bus.conv_d1 <= 4'd0;
      bus.conv_d0 <= 4'd0;
      bus.op_a    <= 11'd0;
      bus.op_b    <= 11'd0;
      bus.conv_en <= 1'b0;
      bus.busy    <= 1'b0;
      bus.ready   <= 1'b0;
    end else begin
      bus.conv_en <= 1'b0;
      bus.ready   <= 1'b0;
      if (do_clr) begin
        state       <= ENT_A;
        cnt         <= 2'd0;
        bus.conv_d2 <= 4'd0;
        bus.conv_d1 <= 4'd0;
        bus.conv_d0 <= 4'd0;
        bus.op_a    <= 11'd0;
        bus.op_b    <= 11'd0;
      end else begin
        case (state)
          ENT_A, ENT_B: begin
            if (key_dig) begin
              // Fourth and later digits leave the registers untouched.
              if (cnt != 2'd3) begin
                bus.conv_d2 <= bus.conv_d1;
                bus.conv_d1 <= bus.conv_d0;
                bus.conv_d0 <= bus.key_code;
                cnt         <= cnt + 2'd1;
              end
            end else if (key_op && (state == ENT_A)) begin
              state       <= CONV_A;
              bus.conv_en <= 1'b1;
              bus.busy    <= 1'b1;
            end else if (key_ent && (state == ENT_B)) begin
              state       <= CONV_B;
              bus.conv_en <= 1'b1;
              bus.busy    <= 1'b1;
            end
          end
          // Converter samples the digits here; its result arrives in WAIT.
          CONV_A: state <= WAIT_A;
          CONV_B: state <= WAIT_B;
          WAIT_A: begin
            bus.op_a    <= bus.conv_value;
            cnt         <= 2'd0;
            bus.conv_d2 <= 4'd0;
            bus.conv_d1 <= 4'd0;
            bus.conv_d0 <= 4'd0;
            bus.busy    <= 1'b0;
            state       <= ENT_B;
          end
          WAIT_B: begin
            bus.op_b    <= bus.conv_value;
            cnt         <= 2'd0;
            bus.conv_d2 <= 4'd0;
            bus.conv_d1 <= 4'd0;
            bus.conv_d0 <= 4'd0;
            bus.busy    <= 1'b0;
            bus.ready   <= 1'b1;
            state       <= DONE;
          end
          DONE: begin
            // A digit opens a fresh operand A; operands hold until then.
            if (key_dig) begin
              bus.conv_d2 <= 4'd0;
              bus.conv_d1 <= 4'd0;
              bus.conv_d0 <= bus.key_code;
              cnt         <= 2'd1;
              state       <= ENT_A;
            end
          end
          default: state <= ENT_A;
        endcase
      end
    end
  end

endmodule
